prefetch_instrucoes: RTL and testbench

//   Instruction prefetch stage upstream of the nRisc core. Fetches 8-bit instructions

---
 rtl/prefetch_instrucoes_pkg.sv | 15 +
 rtl/prefetch_instrucoes_if.sv | 30 +++
 rtl/prefetch_instrucoes_fila.sv | 80 ++++++++
 rtl/prefetch_instrucoes.sv | 122 ++++++++++++
 tb/tb_prefetch_instrucoes.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_instrucoes_pkg.sv
// Shared nRisc definitions: instruction/address widths and the prefetch FSM states.
package nrisc_pkg;

  localparam int unsigned OPCODE_W     = 4;
  localparam int unsigned OPERAND_W    = 4;
  localparam int unsigned NRISC_DATA_W = OPCODE_W + OPERAND_W;
  localparam int unsigned NRISC_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/prefetch_instrucoes_if.sv
// Bundle of the memory request channel and the core instruction channel of the prefetcher.
interface prefetch_instrucoes_if
  import nrisc_pkg::*;
#(
  parameter int unsigned ADDR_W = NRISC_ADDR_W,
  parameter int unsigned DATA_W = NRISC_DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              core_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    input  mem_ack, mem_rdata, core_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    output mem_ack, mem_rdata, core_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/prefetch_instrucoes_fila.sv
// fila_instrucoes: DEPTH-entry register FIFO of {pc, instr} pairs with flush and head outputs.
module fila_instrucoes #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      push_pc,
  input  logic [DATA_W-1:0]      push_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic [ADDR_W-1:0]      head_pc,
  output logic [DATA_W-1:0]      head_instr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] pc_d    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = push_pc;
        instr_d[wr_ptr_q] = push_instr;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '{default: '0};
      instr_q  <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];

  // The fetch FSM only requests while there is room, so a push can never land on a full FIFO.
  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == FULL));

endmodule

// File: rtl/prefetch_instrucoes.sv
// Instruction prefetch stage: fetches from slow memory over req/ack into a small FIFO, with redirect/flush.
module prefetch_instrucoes
  import nrisc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = NRISC_ADDR_W,
  parameter int unsigned DATA_W = NRISC_DATA_W
) (
  input logic                   Clock,
  input logic                   reset,
  prefetch_instrucoes_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              instr_valid;
  logic              push;
  logic              pop;

  // Redirect wins over push and pop: a pop in the redirect cycle is not consumed.
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & bus.core_ready & ~bus.redirect;
  assign push        = (state_q == REQ) & bus.mem_ack & ~bus.redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.redirect_pc;
        end else if (count < FULL) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          if (bus.mem_ack) begin
            mem_addr_d = bus.redirect_pc;
          end else begin
            state_d = DROP;
          end
        end else if (bus.mem_ack) begin
          fetch_pc_d = fetch_pc_q + 1'b1;
          if (count_after < FULL) begin
            mem_addr_d = fetch_pc_q + 1'b1;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      DROP: begin
        // The stale request stays on the bus untouched; its data is thrown away when it completes.
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end
        if (bus.mem_ack) begin
          state_d    = REQ;
          mem_addr_d = bus.redirect ? bus.redirect_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fila_instrucoes #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fila (
    .clk        (Clock),
    .rst_n      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect),
    .push_pc    (fetch_pc_q),
    .push_instr (bus.mem_rdata),
    .count      (count),
    .head_pc    (bus.instr_pc),
    .head_instr (bus.instr_out)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = instr_valid;

endmodule

// File: tb/tb_prefetch_instrucoes.sv
// Scoreboard bench for prefetch_instrucoes: memory responder, core model and expected-instruction queue.
module tb_prefetch_instrucoes;
  import nrisc_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = NRISC_ADDR_W;
  localparam int unsigned DW    = NRISC_DATA_W;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } exp_t;

  logic clk;
  logic rst_n;

  prefetch_instrucoes_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prefetch_instrucoes #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .Clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_tests;
  int unsigned   n_fail;
  exp_t          sb[$];
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] stale_addr;
  logic [AW-1:0] redir_pc_v;
  logic [AW-1:0] prev_addr;
  bit            stale;
  bit            ready_v;
  bit            rand_mode;
  bit            redir_fired;
  bit            prev_req;
  bit            prev_ack;
  int unsigned   redir_arm;   // 0 none, 1 in REQ without ack, 2 with ack and pop, 3 immediately
  int unsigned   mem_lat;
  int unsigned   wait_cnt;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) ^ DW'('h5A);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_addr  = '0;
    stale     = 1'b0;
    wait_cnt  = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    redir_arm = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // One clock: observe at the falling edge, then drive memory/core/redirect for the next rising edge.
  task automatic step();
    bit            ack;
    bit            rdy;
    bit            pop;
    bit            redir_now;
    logic [DW-1:0] rdata;
    exp_t          e;
    @(negedge clk);
    check("valid", 32'(bus.instr_valid), 32'(sb.size() != 0));
    if (bus.instr_valid === 1'b1 && sb.size() != 0) begin
      check("head_pc", 32'(bus.instr_pc), 32'(sb[0].pc));
      check("head_ins", 32'(bus.instr_out), 32'(sb[0].ins));
    end
    if (bus.mem_req === 1'b1) check("req_while_full", 32'(sb.size() >= DEPTH), 32'(0));
    if (prev_req && !prev_ack) begin
      check("req_hold", 32'(bus.mem_req), 32'(1));
      check("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
    end

    rdy = rand_mode ? ($urandom_range(0, 1) == 1) : ready_v;
    ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      if (wait_cnt >= mem_lat) begin
        ack      = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end

    redir_now = 1'b0;
    if (redir_arm == 1 && bus.mem_req === 1'b1 && !ack && !stale) redir_now = 1'b1;
    if (redir_arm == 2 && ack && bus.instr_valid === 1'b1 && !stale) begin
      redir_now = 1'b1;
      rdy       = 1'b1;
    end
    if (redir_arm == 3) redir_now = 1'b1;
    if (redir_now) begin
      redir_arm   = 0;
      redir_fired = 1'b1;
    end

    pop   = (bus.instr_valid === 1'b1) && rdy && !redir_now;
    rdata = stale ? DW'('hEE) : mem_word(bus.mem_addr);

    if (pop && sb.size() != 0) sb.delete(0);
    if (redir_now) begin
      sb.delete();
      if (ack) begin
        stale = 1'b0;
      end else if (bus.mem_req === 1'b1 && !stale) begin
        stale      = 1'b1;
        stale_addr = exp_addr;
      end
      exp_addr = redir_pc_v;
    end else if (ack) begin
      if (stale) begin
        check("stale_addr", 32'(bus.mem_addr), 32'(stale_addr));
        stale = 1'b0;
      end else begin
        check("fetch_addr", 32'(bus.mem_addr), 32'(exp_addr));
        e.pc  = exp_addr;
        e.ins = mem_word(exp_addr);
        sb.push_back(e);
        exp_addr = exp_addr + 1'b1;
      end
    end

    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? rdata : '0;
    bus.core_ready  = rdy;
    bus.redirect    = redir_now;
    bus.redirect_pc = redir_now ? redir_pc_v : '0;
    prev_req  = (bus.mem_req === 1'b1);
    prev_ack  = ack;
    prev_addr = bus.mem_addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] old_addr;
    bit            ok;
    n_tests = 0;
    n_fail  = 0;
    rand_mode = 1'b0;
    ready_v = 1'b0;
    redir_fired = 1'b0;
    redir_pc_v = '0;
    stale_addr = '0;
    mem_lat = 1;
    model_reset();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.core_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(bus.mem_req), 32'(0));
    check("rst_addr", 32'(bus.mem_addr), 32'(0));
    check("rst_valid", 32'(bus.instr_valid), 32'(0));
    check("rst_instr", 32'(bus.instr_out), 32'(0));
    check("rst_pc", 32'(bus.instr_pc), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fast memory fills the FIFO with 00..03, then streams out.
    for (int i = 0; i < 30 && sb.size() < DEPTH; i++) step();
    check("t1_filled", 32'(sb.size()), 32'(DEPTH));
    settle();
    check("t1_idle_req", 32'(bus.mem_req), 32'(0));
    check("t1_head_pc", 32'(bus.instr_pc), 32'(0));
    for (int i = 0; i < 3; i++) step();
    ready_v = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // 2: slow memory; request held, valid one cycle after ack.
    mem_lat = 3;
    for (int i = 0; i < 12 && !prev_ack; i++) step();
    check("t2_ack_seen", 32'(prev_ack), 32'(1));
    settle();
    check("t2_valid_after_ack", 32'(bus.instr_valid), 32'(1));
    for (int i = 0; i < 20; i++) step();

    // 3: redirect to 40 while a request is outstanding without ack.
    redir_pc_v = AW'('h40);
    redir_fired = 1'b0;
    redir_arm = 1;
    for (int i = 0; i < 30 && !redir_fired; i++) step();
    check("t3_fired", 32'(redir_fired), 32'(1));
    old_addr = stale_addr;
    settle();
    check("t3_drop_req", 32'(bus.mem_req), 32'(1));
    check("t3_drop_addr", 32'(bus.mem_addr), 32'(old_addr));
    check("t3_drop_valid", 32'(bus.instr_valid), 32'(0));
    for (int i = 0; i < 10 && stale; i++) step();
    check("t3_stale_done", 32'(stale), 32'(0));
    settle();
    check("t3_new_addr", 32'(bus.mem_addr), 32'('h40));
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      settle();
      ok = (bus.instr_valid === 1'b1);
    end
    check("t3_first_valid", 32'(ok), 32'(1));
    check("t3_first_pc", 32'(bus.instr_pc), 32'('h40));

    // 4: redirect to 10 in the same cycle as an ack and a core pop.
    ready_v = 1'b0;
    mem_lat = 1;
    redir_pc_v = AW'('h10);
    redir_fired = 1'b0;
    redir_arm = 2;
    for (int i = 0; i < 40 && !redir_fired; i++) step();
    check("t4_fired", 32'(redir_fired), 32'(1));
    settle();
    check("t4_flushed", 32'(bus.instr_valid), 32'(0));
    check("t4_req", 32'(bus.mem_req), 32'(1));
    check("t4_addr", 32'(bus.mem_addr), 32'('h10));
    ready_v = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // 5: wrap FE, FF, 00.
    ready_v = 1'b0;
    mem_lat = 0;
    redir_pc_v = AW'('hFE);
    redir_fired = 1'b0;
    redir_arm = 3;
    for (int i = 0; i < 40 && !(redir_fired && sb.size() == DEPTH); i++) step();
    check("t5_filled", 32'(sb.size()), 32'(DEPTH));
    settle();
    check("t5_idle_req", 32'(bus.mem_req), 32'(0));
    check("t5_head_pc", 32'(bus.instr_pc), 32'('hFE));
    check("t5_head_ins", 32'(bus.instr_out), 32'(mem_word(AW'('hFE))));
    ready_v = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // 6: random core_ready, random latency, occasional redirects.
    rand_mode = 1'b1;
    for (int i = 0; i < 240; i++) begin
      if (i % 40 == 0) mem_lat = $urandom_range(0, 2);
      if (i % 60 == 30) begin
        redir_pc_v = AW'($urandom());
        redir_arm  = 3;
      end
      step();
    end

    // Asynchronous reset while a request is outstanding.
    rand_mode = 1'b0;
    ready_v = 1'b0;
    mem_lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      settle();
      ok = (bus.mem_req === 1'b1) && (bus.instr_valid === 1'b1);
    end
    check("t6_req_found", 32'(ok), 32'(1));
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    bus.core_ready = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus.mem_req), 32'(0));
    check("t6_rst_valid", 32'(bus.instr_valid), 32'(0));
    check("t6_rst_addr", 32'(bus.mem_addr), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 20 && sb.size() < 2; i++) step();
    check("t6_refetch", 32'(sb.size()), 32'(2));
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
